// File: rtl/fifo_cdcc_pkg.sv
// Shared constants and types for the CDC FIFO read and write sides.
// Holds pointer widths and the read skid stage state encoding.
package fifo_cdcc_pkg;

    // Pointer geometry shared by the gray-pointer controllers.
    localparam int ADDR_BITS = 4;
    localparam int PTR_BITS  = ADDR_BITS + 1;

    // Read skid stage occupancy states; the encoding equals the level.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    function automatic logic [1:0] skid_level(input skid_state_e s);
        logic [1:0] lvl;
        lvl = 2'd0;
        unique case (s)
            ONE:     lvl = 2'd1;
            TWO:     lvl = 2'd2;
            default: lvl = 2'd0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/fifo_read_skid_stage.sv
// Read-side output stage of the CDC FIFO: two-entry skid buffer with a
// registered ready toward the read controller and valid/ready output.
//
// Ports:
//   rd_clk, rd_rst    read clock, async active-high reset
//   i_valid, i_data   tail word from controller / BRAM
//   o_dready          accept (registered) back to the controller
//   i_flush           synchronous discard of buffered words
//   o_valid, o_data   output word, held while stalled
//   i_dready          downstream ready
//   o_level           buffered words, 0..2
//   o_count           words delivered since reset, wraps
module fifo_read_skid_stage
    import fifo_cdcc_pkg::*;
#(
    parameter int INT_DATA_WIDTH = 32,
    parameter int INT_CNT_BITS   = 32
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic                      i_valid,
    input  logic [INT_DATA_WIDTH-1:0] i_data,
    output logic                      o_dready,
    input  logic                      i_flush,
    output logic                      o_valid,
    output logic [INT_DATA_WIDTH-1:0] o_data,
    input  logic                      i_dready,
    output logic [1:0]                o_level,
    output logic [INT_CNT_BITS-1:0]   o_count
);

    skid_state_e               state_q;
    skid_state_e               state_d;
    logic [INT_DATA_WIDTH-1:0] main_q;
    logic [INT_DATA_WIDTH-1:0] skid_q;
    logic                      dready_q;
    logic [INT_CNT_BITS-1:0]   count_q;

    logic ut;
    logic dt;
    logic load_main;
    logic main_from_skid;
    logic load_skid;

    assign ut = i_valid & dready_q;
    assign dt = (state_q != EMPTY) & i_dready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (ut) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (ut && dt) begin
                    load_main = 1'b1;
                end else if (ut) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (dt) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // ready is low here, so only a drain can happen
                if (dt) begin
                    state_d        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // flush drops buffered words; a concurrent UT is swallowed
        if (i_flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q  <= EMPTY;
            dready_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            dready_q <= (state_d != TWO);
            if (dt) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // data path carries no reset; validity comes from state_q
    always_ff @(posedge rd_clk) begin
        if (load_main) begin
            main_q <= main_from_skid ? skid_q : i_data;
        end
        if (load_skid) begin
            skid_q <= i_data;
        end
    end

    assign o_dready = dready_q;
    assign o_valid  = (state_q != EMPTY);
    assign o_data   = main_q;
    assign o_level  = skid_level(state_q);
    assign o_count  = count_q;

endmodule

// File: tb/tb_fifo_read_skid_stage.sv
// Directed bench for fifo_read_skid_stage, plus a 4-bit counter
// instance sharing the same stimulus to exercise count wrap.
module tb_fifo_read_skid_stage;

    logic        rd_clk;
    logic        rd_rst;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_flush;
    logic        i_dready;

    logic        o_dready;
    logic        o_valid;
    logic [31:0] o_data;
    logic [1:0]  o_level;
    logic [31:0] o_count;

    logic        o_dready4;
    logic        o_valid4;
    logic [31:0] o_data4;
    logic [1:0]  o_level4;
    logic [3:0]  o_count4;

    int total;
    int bad;

    fifo_read_skid_stage #(
        .INT_DATA_WIDTH(32),
        .INT_CNT_BITS  (32)
    ) dut (
        .rd_clk  (rd_clk),
        .rd_rst  (rd_rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_dready(o_dready),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_dready(i_dready),
        .o_level (o_level),
        .o_count (o_count)
    );

    fifo_read_skid_stage #(
        .INT_DATA_WIDTH(32),
        .INT_CNT_BITS  (4)
    ) dut4 (
        .rd_clk  (rd_clk),
        .rd_rst  (rd_rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_dready(o_dready4),
        .i_flush (i_flush),
        .o_valid (o_valid4),
        .o_data  (o_data4),
        .i_dready(i_dready),
        .o_level (o_level4),
        .o_count (o_count4)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rd_rst   = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_flush  = 1'b0;
        i_dready = 1'b0;

        // reset state
        step();
        step();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_dready", 32'(o_dready), 32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_count", o_count, 32'd0);
        rd_rst = 1'b0;
        #1;
        check("rel_dready_pre", 32'(o_dready), 32'd0);
        step();
        check("rel_dready_post", 32'(o_dready), 32'd1);

        // stream 1..16 at full rate
        i_dready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            i_valid = 1'b1;
            i_data  = 32'(k);
            check("str_dready", 32'(o_dready), 32'd1);
            step();
            check("str_valid", 32'(o_valid), 32'd1);
            check("str_data", o_data, 32'(k));
            check("str_level", 32'(o_level), 32'd1);
        end
        i_valid = 1'b0;
        step();
        check("str_count", o_count, 32'd16);
        check("str_level_end", 32'(o_level), 32'd0);
        check("wrap4_16", {28'd0, o_count4}, 32'd0);

        // back-pressure with A,B,C
        i_valid = 1'b1;
        i_data  = 32'h0000_00A0;
        step();
        check("bp_a_data", o_data, 32'h0000_00A0);
        i_dready = 1'b0;
        i_data   = 32'h0000_00B0;
        step();
        check("bp_level2", 32'(o_level), 32'd2);
        check("bp_dready0", 32'(o_dready), 32'd0);
        check("bp_hold1", o_data, 32'h0000_00A0);
        i_data = 32'h0000_00C0;
        step();
        check("bp_hold2", o_data, 32'h0000_00A0);
        check("bp_valid2", 32'(o_valid), 32'd1);
        step();
        check("bp_hold3", o_data, 32'h0000_00A0);
        check("bp_level3", 32'(o_level), 32'd2);
        i_dready = 1'b1;
        step();
        check("bp_b_data", o_data, 32'h0000_00B0);
        check("bp_b_level", 32'(o_level), 32'd1);
        check("bp_b_dready", 32'(o_dready), 32'd1);
        check("bp_count17", o_count, 32'd17);
        check("wrap4_17", {28'd0, o_count4}, 32'd1);
        step();
        check("bp_c_data", o_data, 32'h0000_00C0);
        i_valid = 1'b0;
        step();
        check("bp_empty", 32'(o_level), 32'd0);
        check("bp_count19", o_count, 32'd19);

        // i_valid toggling
        i_valid = 1'b1;
        i_data  = 32'h0000_0011;
        step();
        check("tg_v1", 32'(o_valid), 32'd1);
        check("tg_l1", 32'(o_level), 32'd1);
        check("tg_d1", o_data, 32'h0000_0011);
        i_valid = 1'b0;
        step();
        check("tg_v0", 32'(o_valid), 32'd0);
        check("tg_l0", 32'(o_level), 32'd0);
        i_valid = 1'b1;
        i_data  = 32'h0000_0022;
        step();
        check("tg_v1b", 32'(o_valid), 32'd1);
        check("tg_d2", o_data, 32'h0000_0022);
        i_valid = 1'b0;
        step();
        check("tg_l0b", 32'(o_level), 32'd0);
        check("tg_count", o_count, 32'd21);

        // fill to TWO, then flush
        i_dready = 1'b0;
        i_valid  = 1'b1;
        i_data   = 32'hAAAA_0001;
        step();
        i_data = 32'hAAAA_0002;
        step();
        check("fl_level2", 32'(o_level), 32'd2);
        check("fl_dready0", 32'(o_dready), 32'd0);
        check("fl_data", o_data, 32'hAAAA_0001);
        i_valid = 1'b0;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("fl_valid", 32'(o_valid), 32'd0);
        check("fl_level", 32'(o_level), 32'd0);
        check("fl_dready", 32'(o_dready), 32'd1);
        check("fl_count", o_count, 32'd21);

        // async reset while in TWO
        i_valid = 1'b1;
        i_data  = 32'h0000_5001;
        step();
        i_data = 32'h0000_5002;
        step();
        i_valid = 1'b0;
        check("ar_level2", 32'(o_level), 32'd2);
        @(negedge rd_clk);
        rd_rst = 1'b1;
        #1;
        check("ar_valid", 32'(o_valid), 32'd0);
        check("ar_dready", 32'(o_dready), 32'd0);
        check("ar_count", o_count, 32'd0);
        check("ar_level", 32'(o_level), 32'd0);
        step();
        rd_rst = 1'b0;
        step();
        check("ar_dready_up", 32'(o_dready), 32'd1);
        i_dready = 1'b1;
        i_valid  = 1'b1;
        i_data   = 32'h0000_C0DE;
        step();
        check("ar_new_valid", 32'(o_valid), 32'd1);
        check("ar_new_data", o_data, 32'h0000_C0DE);
        i_valid = 1'b0;
        step();
        check("ar_new_count", o_count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_read_skid_stage.md
# fifo_read_skid_stage

Read-side output stage of the CDC FIFO, clocked in the read domain directly downstream of the gray-pointer read controller and the BRAM read port. Takes each word the controller qualifies as valid and buffers it in a two-entry skid register. Presents it on an AXI-stream-style valid/ready port. The ready path is fully registered, so the downstream consumer's ready never propagates combinationally into the controller's pointer logic.

## Interface
- INT_DATA_WIDTH, 32, width of BRAM read data and output data
- INT_CNT_BITS, 32, width of the delivered-word counter
- rd_clk  in  1  read-domain clock; all logic on rising edge
- rd_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_valid  in  1  word at the FIFO tail is valid (controller valid flag)
- i_data  in  INT_DATA_WIDTH  BRAM read data for the current tail word
- o_dready  out  1  this stage accepts a word this cycle (drives the controller's ready input)
- i_flush  in  1  synchronous discard of all buffered words
- o_valid  out  1  output word valid
- o_data  out  INT_DATA_WIDTH  output word
- i_dready  in  1  downstream consumer ready
- o_level  out  2  buffered words, 0..2
- o_count  out  INT_CNT_BITS  words delivered downstream since reset, wraps

## Operation
- Upstream transfer (UT): cycle with i_valid=1 and o_dready=1; i_data in that cycle is the transferred word.
- Downstream transfer (DT): cycle with o_valid=1 and i_dready=1.
- Storage: main register (drives o_data) and skid register.
- FSM states and transitions (flush excluded):
  - EMPTY
    - UT -> ONE, main<=i_data.
  - ONE
    - UT&DT -> ONE, main<=i_data.
    - UT only -> TWO, skid<=i_data.
    - DT only -> EMPTY.
    - Neither -> hold.
  - TWO (o_dready=0, so no UT)
    - DT -> ONE, main<=skid.
    - Otherwise hold.
- o_valid = state!=EMPTY; o_level = 0/1/2 for EMPTY/ONE/TWO.
- o_dready is a flop. Next value is 1 unless the next state is TWO or rd_rst is asserted.
- o_count increments by 1 on every DT, wraps from 2^INT_CNT_BITS-1 to 0. It is not cleared by flush.
- Flush: i_flush=1 forces the next state to EMPTY and o_dready to 1 next cycle.
  - A UT in the flush cycle is consumed and discarded; the controller pointer still advances.
  - A DT in the flush cycle completes normally and is counted.
- Data path registers have no reset. State, o_dready and o_count have reset.

## Timing
- Reset values (asynchronous, while rd_rst=1):
  - State EMPTY.
  - o_valid=0, o_dready=0, o_level=0, o_count=0.
  - o_data undefined (don't-care).
- o_dready rises on the first rd_clk edge after rd_rst deasserts.
- Latency: a UT in cycle n gives o_valid=1 and o_data=word in cycle n+1 when the stage was EMPTY, or when in ONE with a DT in cycle n.
- Throughput: one word per cycle sustained while i_valid and i_dready stay high (state remains ONE).
- Back-pressure: i_dready low in ONE with a UT gives TWO in n+1 and o_dready=0 in n+1.
  - At most one word is absorbed after downstream stall.
  - No word is lost or duplicated.
- Word order out equals UT order.
- o_valid must not drop, and o_data must not change, while o_valid=1 and i_dready=0 (AXI hold rule). Flush is the only exception.
- Reset mid-operation: buffered words are dropped immediately; o_count returns to 0.

## Structure
- State encoding localparams (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) go in the shared fifo_cdcc package next to the pointer-width constants.
- Single module; no sub-module. Main and skid registers are inline.

## Test plan
- Reset then stream 0x00000001..0x00000010 with i_valid=1, i_dready=1.
  - o_dready=1 from first edge after reset.
  - Outputs appear one per cycle, 1-cycle latency.
  - o_count=16, o_level stays 1.
- Stream words A,B,C with i_dready dropped for 3 cycles after A is presented.
  - State goes ONE->TWO and o_dready=0 within 1 cycle.
  - A is held stable during the stall.
  - Output order A,B,C; no loss.
- i_valid toggling 1,0,1,0 with i_dready=1.
  - o_valid follows with 1-cycle delay.
  - o_level alternates 1,0.
- Fill to TWO with 0xAAAA0001, 0xAAAA0002, then assert i_flush one cycle with i_dready=0.
  - Next cycle: o_valid=0, o_level=0, o_dready=1.
  - o_count unchanged.
- Assert rd_rst asynchronously mid-stream in state TWO.
  - o_valid and o_dready go 0 immediately, o_count=0, with no rd_clk edge needed.
  - After release, first new word delivered correctly.
- INT_CNT_BITS=4: deliver 17 words → o_count wraps to 1.
